// File: rtl/nextasic_audio_pkg.sv
// Shared types and widths for the monitor-link audio path.
// Holds the audio word layout and the sample-buffer state encoding.
package nextasic_audio_pkg;

  localparam int AUDIO_WORD_W = 32;
  localparam int AUDIO_CH_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } buf_state_t;

  // Left channel occupies the upper half of the audio word.
  function automatic logic [AUDIO_WORD_W-1:0] pack_word(
    input logic [AUDIO_CH_W-1:0] left,
    input logic [AUDIO_CH_W-1:0] right
  );
    return {left, right};
  endfunction

endpackage

// File: rtl/audio_sample_buffer_if.sv
// Audio word handshake between the monitor-link decoder, the sample buffer and the I2S serializer.
// The buffer is the slave side; whoever drives words in and pulls them out is the master.
interface audio_sample_buffer_if;
  import nextasic_audio_pkg::*;

  logic                    in_valid;
  logic [AUDIO_WORD_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [AUDIO_WORD_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/audio_word_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and a flush that discards all stored words.
// The caller gates writes against full; a flush keeps only a word written in the same cycle.
module audio_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Flush snaps the read pointer onto the old write pointer, so a same-cycle write survives as the only entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= i_wr_en ? CW'(1) : CW'(0);
      end else begin
        if (i_rd_en) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({i_wr_en, i_rd_en})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;

endmodule

// File: rtl/audio_sample_buffer.sv
// Elastic audio word buffer between the monitor-link op decoder and the I2S serializer.
// Prefills before playback, paces host data with spaced audio_req pulses, and latches underrun/overflow.
module audio_sample_buffer
  import nextasic_audio_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int REQ_THRESHOLD = 8,
  parameter int REQ_HOLDOFF   = 143
) (
  input  logic                    mon_clk,
  input  logic                    reset,
  audio_sample_buffer_if.slave    bus,
  input  logic                    audio_start,
  output logic                    audio_req,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underrun,
  output logic                    overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (REQ_HOLDOFF > 1) ? $clog2(REQ_HOLDOFF) : 1;

  buf_state_t              r_state;
  logic                    r_audio_req;
  logic                    r_underrun;
  logic                    r_overflow;
  logic [HW-1:0]           r_holdoff;

  logic                    w_full;
  logic                    w_empty;
  logic [CW-1:0]           w_count;
  logic [AUDIO_WORD_W-1:0] w_head;
  logic                    w_out_en;
  logic                    w_out_valid;
  logic                    w_rd;
  logic                    w_wr;
  logic                    w_flush;
  logic                    w_start_stream;
  logic                    w_req_fire;
  logic                    w_drop;
  logic                    w_starved_pull;

  audio_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AUDIO_WORD_W)
  ) u_fifo (
    .clk       (mon_clk),
    .reset     (reset),
    .i_wr_en   (w_wr),
    .i_wr_data (bus.in_data),
    .i_rd_en   (w_rd),
    .i_flush   (w_flush),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_out_en    = (r_state == RUN) || (r_state == DRAIN);
  assign w_out_valid = w_out_en && !w_empty;
  assign w_rd        = bus.out_ready && w_out_valid;

  // A full buffer still accepts a word when the serializer frees a slot in the same cycle.
  assign w_wr           = bus.in_valid && (!w_full || w_rd);
  assign w_drop         = bus.in_valid && w_full && !w_rd;
  assign w_starved_pull = (r_state == RUN) && bus.out_ready && w_empty;

  // Residual words are discarded exactly on the edge that lands the FSM in IDLE.
  assign w_flush = ((r_state == PRIME) && !audio_start) ||
                   ((r_state == DRAIN) && !audio_start && w_empty);

  assign w_start_stream = (r_state == IDLE) && audio_start;
  assign w_req_fire     = ((r_state == PRIME) || (r_state == RUN)) &&
                          (w_count <= CW'(REQ_THRESHOLD)) &&
                          (r_holdoff == '0);

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_audio_req <= 1'b0;
      r_underrun  <= 1'b0;
      r_overflow  <= 1'b0;
      r_holdoff   <= '0;
    end else begin
      r_audio_req <= w_req_fire;
      if (w_req_fire) begin
        r_holdoff <= HW'(REQ_HOLDOFF - 1);
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - HW'(1);
      end

      r_overflow <= (w_start_stream ? 1'b0 : r_overflow) | w_drop;
      r_underrun <= (w_start_stream ? 1'b0 : r_underrun) | w_starved_pull;

      case (r_state)
        IDLE: begin
          if (audio_start) begin
            r_state <= PRIME;
          end
        end
        PRIME: begin
          if (!audio_start) begin
            r_state <= IDLE;
          end else if (w_count >= CW'(REQ_THRESHOLD)) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!audio_start) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (audio_start) begin
            r_state <= RUN;
          end else if (w_empty) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_head : '0;
  assign audio_req     = r_audio_req;
  assign level         = w_count;
  assign underrun      = r_underrun;
  assign overflow      = r_overflow;

endmodule
